keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, the clk frequency.
REQ-002 SHALL have parameter SCAN_RATE_IN_HERTZ, default 1000, the column-step rate.
REQ-003 SHALL have parameter DEBOUNCE_SCANS, default 4, the consecutive scan ticks required to accept a press or release.
REQ-004 SHALL define localparam CYCLES_PER_SCAN = BOARD_CLOCK_FREQUENCY_IN_HZ / SCAN_RATE_IN_HERTZ.
REQ-005 Ports:
- clk  input  1  the single clock; all state is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- io_row  input  4  keypad rows; active-low, pulled up externally, asynchronous to clk.
- io_col  output  4  column drive; active-low one-hot.
- key  output  4  code of the accepted key.
- key_valid  output  1  key holds an unconsumed code.
- key_ack  input  1  consumer strobe that clears key_valid.
- overflow  output  1  sticky flag: a key was dropped.

Function
REQ-006 SHALL pass io_row through a 2-flop synchronizer; all logic SHALL use only the synchronized row.
REQ-007 SHALL generate a 1-cycle scan tick every CYCLES_PER_SCAN clocks from a free-running counter that wraps at CYCLES_PER_SCAN-1.
REQ-008 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-009 SCAN: on each tick, io_col SHALL advance 0->1->2->3->0. On a tick where any synchronized row is low, the FSM SHALL latch the column and row pattern, freeze io_col, clear the debounce count, and go to DEBOUNCE.
REQ-010 DEBOUNCE: on each tick, if the row pattern equals the latched pattern, the count SHALL increment; otherwise the FSM SHALL return to SCAN. When the count reaches DEBOUNCE_SCANS, the key SHALL be accepted and the FSM SHALL go to HELD.
REQ-011 HELD: the FSM SHALL wait until a tick sees all rows high, then go to RELEASE with the count cleared.
REQ-012 RELEASE: each all-high tick SHALL increment the count and any low row SHALL return the FSM to HELD. At DEBOUNCE_SCANS, the FSM SHALL go to SCAN and io_col SHALL resume from the next column.
REQ-013 When multiple rows are low, the lowest row index SHALL win. Only one key SHALL be reported per press-release cycle.
REQ-014 Key code mapping by (row,col):
- row0: 1,2,3,A
- row1: 4,5,6,B
- row2: 7,8,9,C
- row3: E,0,F,D
REQ-015 On acceptance with key_valid=0, key SHALL load and key_valid SHALL rise on the next clock. This is 1 cycle after the accepting tick.
REQ-016 key_ack with key_valid=1 SHALL clear key_valid on the next clock. key_ack with key_valid=0 SHALL be ignored.
REQ-017 Acceptance and key_ack in the same cycle SHALL load the new code with key_valid=1 and SHALL NOT set overflow.
REQ-018 Acceptance while key_valid=1 without key_ack SHALL keep the old code and set overflow. Overflow SHALL clear only on key_ack or reset.
REQ-019 key SHALL remain stable while key_valid=1.

Reset
REQ-020 rst low SHALL asynchronously force the following:
- FSM=SCAN, io_col=4'b1110, all counters 0, synchronizer flops 1.
- key=0, key_valid=0, overflow=0.
REQ-021 Reset mid-debounce or mid-hold SHALL discard the key in progress. After rst rises, the first key SHALL need a fresh full debounce.

Structure
REQ-022 The state encoding and the 16-entry key code table SHALL live in the shared package keypad_pkg.
REQ-023 The row/column-to-code lookup SHALL be the combinational sub-module keypad_decode. Counters and the FSM SHALL stay in keypad_scanner.

Verification
Bench parameters: BOARD_CLOCK_FREQUENCY_IN_HZ=1000, SCAN_RATE_IN_HERTZ=100 (10 clocks/tick), DEBOUNCE_SCANS=3.
REQ-024 Reset release, no keys -> io_col steps 1110, 1101, 1011, 0111, 1110 every 10 clocks; key_valid=0; overflow=0.
REQ-025 Model pulls row1 low while col2 is driven, for 3+ ticks, then releases -> key=6, key_valid=1 one cycle after the 3rd matching tick. Exactly one report; scanning resumes at col3 after 3 high ticks.
REQ-026 Row0 toggled low on ticks 1 and 3 and high on tick 2 (bounce) -> FSM returns to SCAN and key_valid stays 0.
REQ-027 Key '0' accepted without ack, then key '5' accepted -> key=0 retained, overflow=1. key_ack -> key_valid=0 and overflow=0 next clock.
REQ-028 key_ack asserted in the acceptance cycle of key 'D' while key 'A' is pending -> key=D, key_valid=1, overflow=0.
REQ-029 rst low during DEBOUNCE with row2 low -> outputs at reset values immediately. After release, the held key needs 3 new ticks before key=8 (col1) appears.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding and key code table.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // Key codes indexed by {row, col}; entry 0 is row0/col0, entry 15 is row3/col3.
  // Row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: E 0 F D.
  localparam logic [15:0][3:0] KEY_TABLE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Look up the code of the key at the given row and column.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_TABLE[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational row/column to key code lookup; the lowest active (low) row wins.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row_n_i,
  input  logic [1:0] col_i,
  output logic [3:0] code_o
);

  logic [1:0] row_idx;

  // Pick the lowest-index low row by scanning from the top down, then look up the code.
  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_n_i[r]) begin
        row_idx = 2'(r);
      end
    end
    code_o = key_code(row_idx, col_i);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with row synchronizer, scan-tick timing, press/release
// debounce FSM and a single-entry output register with overflow flag.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int SCAN_RATE_IN_HERTZ          = 1000,
  parameter int DEBOUNCE_SCANS              = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] io_row,
  output logic [3:0] io_col,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overflow
);

  localparam int CYCLES_PER_SCAN = BOARD_CLOCK_FREQUENCY_IN_HZ / SCAN_RATE_IN_HERTZ;
  localparam int TICK_W = (CYCLES_PER_SCAN > 1) ? $clog2(CYCLES_PER_SCAN) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_SCAN - 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic [3:0]        row_meta_q;
  logic [3:0]        row_sync_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              scan_tick;
  scan_state_e       state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        pattern_q, pattern_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [DB_W-1:0]   db_cnt_inc;
  logic              rows_idle;
  logic              accept;
  logic [3:0]        decoded_code;
  logic [3:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              overflow_q, overflow_d;

  // Two-flop synchronizer for the asynchronous rows; idles high like the pulled-up lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= io_row;
      row_sync_q <= row_meta_q;
    end
  end

  assign scan_tick  = (tick_cnt_q == TICK_LAST);
  assign rows_idle  = &row_sync_q;
  assign db_cnt_inc = db_cnt_q + DB_W'(1);

  // Free-running scan-rate counter; the tick is the cycle where it sits at its last value.
  always_comb begin
    tick_cnt_d = scan_tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Scan-rate counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // FSM and column/pattern/debounce state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SCAN;
      col_q     <= 2'd0;
      pattern_q <= 4'hF;
      db_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      pattern_q <= pattern_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Next-state logic: everything moves only on scan ticks; the column stays frozen from detection until release completes.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pattern_d = pattern_q;
    db_cnt_d  = db_cnt_q;
    accept    = 1'b0;
    if (scan_tick) begin
      case (state_q)
        ST_SCAN: begin
          if (!rows_idle) begin
            pattern_d = row_sync_q;
            db_cnt_d  = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_sync_q == pattern_q) begin
            if (db_cnt_inc == DB_TARGET) begin
              accept   = 1'b1;
              db_cnt_d = '0;
              state_d  = ST_HELD;
            end else begin
              db_cnt_d = db_cnt_inc;
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rows_idle) begin
            db_cnt_d = '0;
            state_d  = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rows_idle) begin
            if (db_cnt_inc == DB_TARGET) begin
              db_cnt_d = '0;
              col_d    = col_q + 2'd1;
              state_d  = ST_SCAN;
            end else begin
              db_cnt_d = db_cnt_inc;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  keypad_decode u_decode (
    .row_n_i (pattern_q),
    .col_i   (col_q),
    .code_o  (decoded_code)
  );

  // Output register update: ack frees the slot, and an accept in the same cycle may reuse it.
  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_d       = decoded_code;
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign io_col    = ~(4'b0001 << col_q);
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: models a physical 4x4 keypad on the column/row wires and
// checks timing-exact sequences, a vector table and randomized press/release cycles.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ioRow;
  logic [3:0]  ioCol;
  logic [3:0]  key;
  logic        keyValid;
  logic        keyAck = 1'b0;
  logic        overflow;

  logic [15:0] pressed = 16'h0;
  logic [3:0]  forceLow = 4'h0;
  int          cyc;
  int          checks = 0;
  int          failures = 0;

  logic [3:0]  codeTable [16];
  logic        mValid;
  logic        mOv;
  logic [3:0]  mKey;

  typedef struct {
    bit          ackFirst;
    logic [15:0] mask;
    logic [3:0]  expKey;
    logic        expValid;
    logic        expOv;
  } vec_t;

  vec_t vecs [8];

  keypad_scanner #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
    .SCAN_RATE_IN_HERTZ          (100),
    .DEBOUNCE_SCANS              (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io_row    (ioRow),
    .io_col    (ioCol),
    .key       (key),
    .key_valid (keyValid),
    .key_ack   (keyAck),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; tick edges fall on multiples of ten.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Keypad matrix: a pressed switch shorts its row to a driven (low) column; forceLow models contact bounce.
  always_comb begin
    ioRow = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !ioCol[c]) ioRow[r] = 1'b0;
      end
    end
    ioRow = ioRow & ~forceLow;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic gotoCycle(input int k);
    if (cyc > k) begin
      checks++;
      failures++;
      $display("[TB] FAIL schedule: actual cyc=%0d required<=%0d", cyc, k);
    end
    while (cyc < k) @(negedge clk);
  endtask

  task automatic waitTicks(input int n);
    repeat (n * 10) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    pressed = 16'h0;
    forceLow = 4'h0;
    keyAck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Model of the consumer handshake: ack frees a pending key and clears overflow.
  task automatic pulseAck();
    if (mValid) begin
      mValid = 1'b0;
      mOv = 1'b0;
    end
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    checkOutput("ack_valid", {7'd0, keyValid}, {7'd0, mValid});
    checkOutput("ack_overflow", {7'd0, overflow}, {7'd0, mOv});
  endtask

  // Model of one accepted key: fills the empty slot or flags a drop.
  task automatic modelAccept(input logic [3:0] code);
    if (!mValid) begin
      mKey = code;
      mValid = 1'b1;
    end else begin
      mOv = 1'b1;
    end
  endtask

  // One complete press/hold/release cycle, optionally preceded by an ack.
  task automatic applyStimulus(input bit ackFirst, input logic [15:0] mask, input int hold, input int rel);
    if (ackFirst) pulseAck();
    pressed = mask;
    waitTicks(hold);
    pressed = 16'h0;
    waitTicks(rel);
  endtask

  initial begin
    logic [3:0] expCols [5];
    logic [3:0] colA;
    int m;

    codeTable = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    vecs[0] = '{1'b0, 16'h0040, 4'h6, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h2000, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h0020, 4'h0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'h0008, 4'hA, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h4040, 4'h6, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h0100, 4'h7, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h8000, 4'hD, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h0001, 4'hD, 1'b1, 1'b1};
    expCols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    mValid = 1'b0;
    mOv = 1'b0;
    mKey = 4'h0;

    // Reset values, then idle column stepping.
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_col", {4'd0, ioCol}, 8'h0E);
    checkOutput("rst_key", {4'd0, key}, 8'h00);
    checkOutput("rst_valid", {7'd0, keyValid}, 8'h00);
    checkOutput("rst_overflow", {7'd0, overflow}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gotoCycle(5 + 10 * i);
      checkOutput($sformatf("idle_col%0d", i), {4'd0, ioCol}, {4'd0, expCols[i]});
    end
    checkOutput("idle_valid", {7'd0, keyValid}, 8'h00);
    checkOutput("idle_overflow", {7'd0, overflow}, 8'h00);

    // Key 6 (row1, col2) held from reset: found on the col2 tick, accepted three ticks later.
    resetDut();
    pressed = 16'h0040;
    gotoCycle(59);
    checkOutput("k6_before", {7'd0, keyValid}, 8'h00);
    gotoCycle(60);
    checkOutput("k6_valid", {7'd0, keyValid}, 8'h01);
    checkOutput("k6_key", {4'd0, key}, 8'h06);
    gotoCycle(65);
    pressed = 16'h0;
    gotoCycle(95);
    checkOutput("k6_col_frozen", {4'd0, ioCol}, 8'h0B);
    gotoCycle(105);
    checkOutput("k6_col_resume", {4'd0, ioCol}, 8'h07);
    gotoCycle(140);
    checkOutput("k6_single_report", {7'd0, overflow}, 8'h00);
    checkOutput("k6_still_key", {4'd0, key}, 8'h06);
    mValid = 1'b1;
    mKey = 4'h6;
    pulseAck();

    // Bounce on row0: low, high, low, high across four ticks never reaches acceptance.
    m = ((cyc / 10) + 1) * 10 + 5;
    gotoCycle(m);
    forceLow = 4'b0001;
    gotoCycle(m + 10);
    forceLow = 4'b0000;
    gotoCycle(m + 20);
    forceLow = 4'b0001;
    gotoCycle(m + 30);
    forceLow = 4'b0000;
    gotoCycle(m + 40);
    colA = ioCol;
    gotoCycle(m + 50);
    checkOutput("bounce_scanning", {4'd0, ioCol}, {4'd0, colA[2:0], colA[3]});
    checkOutput("bounce_valid", {7'd0, keyValid}, 8'h00);

    // Vector table of press/release cycles.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].ackFirst, vecs[i].mask, 12, 7);
      checkOutput($sformatf("tbl%0d_valid", i), {7'd0, keyValid}, {7'd0, vecs[i].expValid});
      checkOutput($sformatf("tbl%0d_key", i), {4'd0, key}, {4'd0, vecs[i].expKey});
      checkOutput($sformatf("tbl%0d_overflow", i), {7'd0, overflow}, {7'd0, vecs[i].expOv});
      mValid = vecs[i].expValid;
      mKey = vecs[i].expKey;
      mOv = vecs[i].expOv;
    end

    // Randomized single-key presses against the slot/overflow model.
    for (int i = 0; i < 12; i++) begin
      int r;
      int c;
      bit doAck;
      logic [15:0] mask;
      doAck = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      mask = 16'h0;
      mask[r*4+c] = 1'b1;
      applyStimulus(doAck, mask, $urandom_range(11, 15), $urandom_range(6, 9));
      modelAccept(codeTable[r*4+c]);
      checkOutput($sformatf("rnd%0d_valid", i), {7'd0, keyValid}, {7'd0, mValid});
      checkOutput($sformatf("rnd%0d_key", i), {4'd0, key}, {4'd0, mKey});
      checkOutput($sformatf("rnd%0d_overflow", i), {7'd0, overflow}, {7'd0, mOv});
    end

    // Ack in the acceptance cycle of D while A is pending, then reset mid-debounce of key 8.
    resetDut();
    pressed = 16'h0008;
    gotoCycle(69);
    checkOutput("kA_before", {7'd0, keyValid}, 8'h00);
    gotoCycle(70);
    checkOutput("kA_key", {4'd0, key}, 8'h0A);
    gotoCycle(75);
    pressed = 16'h0;
    gotoCycle(112);
    pressed = 16'h8000;
    gotoCycle(179);
    checkOutput("kD_pending_A", {4'd0, key}, 8'h0A);
    keyAck = 1'b1;
    gotoCycle(180);
    keyAck = 1'b0;
    checkOutput("kD_key", {4'd0, key}, 8'h0D);
    checkOutput("kD_valid", {7'd0, keyValid}, 8'h01);
    checkOutput("kD_overflow", {7'd0, overflow}, 8'h00);
    gotoCycle(185);
    pressed = 16'h0;
    gotoCycle(222);
    pressed = 16'h0200;
    gotoCycle(254);
    checkOutput("k8_pre_valid", {7'd0, keyValid}, 8'h01);
    checkOutput("k8_pre_col", {4'd0, ioCol}, 8'h0D);
    gotoCycle(255);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_col", {4'd0, ioCol}, 8'h0E);
    checkOutput("midrst_key", {4'd0, key}, 8'h00);
    checkOutput("midrst_valid", {7'd0, keyValid}, 8'h00);
    checkOutput("midrst_overflow", {7'd0, overflow}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    gotoCycle(49);
    checkOutput("k8_before", {7'd0, keyValid}, 8'h00);
    gotoCycle(50);
    checkOutput("k8_valid", {7'd0, keyValid}, 8'h01);
    checkOutput("k8_key", {4'd0, key}, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
